// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the byte-serial memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_WORD3 = 2'd3
  } size_e;

  localparam logic [2:0] IF_BYTES = 3'd4;

  // Encoding 3 is treated as a full word.
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb.sv
// mem_arb: two-way round-robin between fetch and LSB requesters.
module mem_arb (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_lsb_i,
  output logic gnt_if_o,
  output logic gnt_lsb_o
);

  logic last_lsb_q;

  // A lone request always wins; on a tie the side not served last wins.
  always_comb begin
    gnt_if_o  = en_i && req_if_i  && (!req_lsb_i || last_lsb_q);
    gnt_lsb_o = en_i && req_lsb_i && (!req_if_i  || !last_lsb_q);
  end

  // Remember who was granted; LSB out of reset so fetch wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_lsb_q <= 1'b1;
    end else if (gnt_if_o) begin
      last_lsb_q <= 1'b0;
    end else if (gnt_lsb_o) begin
      last_lsb_q <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by instruction fetch and LSB.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request, arbiter active
// ST_READ  | presenting addresses, collecting bytes one cycle behind
// ST_WRITE | presenting address/data bytes, stalls on io_buffer_full
// ST_DONE  | one-cycle done pulse to the granted requester
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [2:0]        k_q;
  logic [2:0]        n_q;
  logic              src_lsb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       rbuf_merged;
  logic [7:0]        next_byte;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              wr_q;
  logic              if_done_q;
  logic              lsb_done_q;
  logic [31:0]       if_data_q;
  logic [31:0]       lsb_rdata_q;
  logic              arb_en;
  logic              gnt_if;
  logic              gnt_lsb;

  assign arb_en = rdy_in && (state_q == ST_IDLE);

  // A flush blocks a fresh fetch grant in the same cycle.
  mem_arb u_arb (
    .clk_i     (clk_in),
    .rst_ni    (rst_in),
    .en_i      (arb_en),
    .req_if_i  (if_req & ~clear),
    .req_lsb_i (lsb_req),
    .gnt_if_o  (gnt_if),
    .gnt_lsb_o (gnt_lsb)
  );

  // Byte arriving now belongs to the address presented one cycle earlier (k-1).
  always_comb begin
    rbuf_merged = rbuf_q;
    case (k_q)
      3'd1:    rbuf_merged[7:0]   = mem_din;
      3'd2:    rbuf_merged[15:8]  = mem_din;
      3'd3:    rbuf_merged[23:16] = mem_din;
      3'd4:    rbuf_merged[31:24] = mem_din;
      default: rbuf_merged        = rbuf_q;
    endcase
  end

  // Write byte for the following beat.
  always_comb begin
    case (k_q)
      3'd0:    next_byte = wdata_q[15:8];
      3'd1:    next_byte = wdata_q[23:16];
      3'd2:    next_byte = wdata_q[31:24];
      default: next_byte = wdata_q[7:0];
    endcase
  end

  // Main sequencer; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      src_lsb_q   <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_if || gnt_lsb) begin
            k_q       <= '0;
            rbuf_q    <= '0;
            src_lsb_q <= gnt_lsb;
            wdata_q   <= lsb_wdata;
            mem_a_q   <= gnt_lsb ? lsb_addr : if_addr;
            n_q       <= gnt_lsb ? size_bytes(size_e'(lsb_size)) : IF_BYTES;
            if (gnt_lsb && lsb_wr) begin
              state_q    <= ST_WRITE;
              wr_q       <= 1'b1;
              mem_dout_q <= lsb_wdata[7:0];
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (clear && !src_lsb_q) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
          end else begin
            if (k_q != 3'd0) begin
              rbuf_q <= rbuf_merged;
            end
            if (k_q == n_q) begin
              state_q <= ST_DONE;
              k_q     <= '0;
              if (src_lsb_q) begin
                lsb_rdata_q <= rbuf_merged;
                lsb_done_q  <= 1'b1;
              end else begin
                if_data_q <= rbuf_merged;
                if_done_q <= 1'b1;
              end
            end else begin
              k_q <= k_q + 3'd1;
              if (k_q + 3'd1 < n_q) begin
                mem_a_q <= mem_a_q + ADDR_ONE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (!io_buffer_full) begin
            if (k_q + 3'd1 == n_q) begin
              state_q    <= ST_DONE;
              wr_q       <= 1'b0;
              k_q        <= '0;
              lsb_done_q <= 1'b1;
            end else begin
              k_q        <= k_q + 3'd1;
              mem_a_q    <= mem_a_q + ADDR_ONE;
              mem_dout_q <= next_byte;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          if_done_q  <= 1'b0;
          lsb_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Back-pressure and rdy_in must suppress the strobe in the same cycle.
  assign mem_wr    = wr_q && rdy_in && !io_buffer_full;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q;
  assign lsb_done  = lsb_done_q;
  assign if_data   = if_data_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a small synchronous RAM model.
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int wr_base  = 0;

  logic [7:0] ram [4096];
  logic [7:0] t2b [4];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_size       (lsb_size),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // RAM with one cycle of read latency.
  always @(posedge clk_in) begin
    if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_wr"},    {31'd0, mem_wr},   32'd0);
    chk({tag, "_mem_a"},     mem_a,             32'd0);
    chk({tag, "_mem_dout"},  {24'd0, mem_dout}, 32'd0);
    chk({tag, "_if_done"},   {31'd0, if_done},  32'd0);
    chk({tag, "_lsb_done"},  {31'd0, lsb_done}, 32'd0);
    chk({tag, "_if_data"},   if_data,           32'd0);
    chk({tag, "_lsb_rdata"}, lsb_rdata,         32'd0);
  endtask

  task automatic drive_lsb(input logic req, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
    lsb_req   = req;
    lsb_wr    = wr;
    lsb_size  = sz;
    lsb_addr  = addr;
    lsb_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    ram[12'h100] <= 8'h11;
    ram[12'h101] <= 8'h22;
    ram[12'h102] <= 8'h33;
    ram[12'h103] <= 8'h44;
    ram[12'hFFE] <= 8'hC1;
    ram[12'hFFF] <= 8'hC2;
    t2b[0] = 8'hD4; t2b[1] = 8'hC3; t2b[2] = 8'hB2; t2b[3] = 8'hA1;

    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    drive_lsb(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Reset state
    tick(); tick();
    chk_all_zero("rst");
    rst_in = 1'b1;
    tick();

    // Lone 4-byte fetch from 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) begin
        chk("t1_mem_a", mem_a, 32'h100 + 32'(c - 1));
        chk("t1_mem_wr", {31'd0, mem_wr}, 32'd0);
      end
      chk("t1_if_done", {31'd0, if_done}, {31'd0, c == 6});
      if (c >= 6) chk("t1_if_data", if_data, 32'h44332211);
      if (c == 6) if_req = 1'b0;
    end

    // Lone SW of 0xA1B2C3D4 to 0x200
    drive_lsb(1'b1, 1'b1, 2'd2, 32'h200, 32'hA1B2C3D4);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        chk("t2_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("t2_mem_a", mem_a, 32'h200 + 32'(c - 1));
        chk("t2_mem_dout", {24'd0, mem_dout}, {24'd0, t2b[c-1]});
      end
      chk("t2_lsb_done", {31'd0, lsb_done}, {31'd0, c == 5});
      if (c == 5) lsb_req = 1'b0;
    end
    chk("t2_ram_hi", {24'd0, ram[12'h203]}, 32'hA1);

    // Both requests high out of reset: IF, then LSB, then IF again
    tick();
    rst_in = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    drive_lsb(1'b1, 1'b0, 2'd0, 32'h103, 32'h0);
    #1;
    rst_in = 1'b1;
    #1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) chk("t3_first_if", mem_a, 32'h100);
      if (c == 6) begin
        chk("t3_if_done", {31'd0, if_done}, 32'd1);
        chk("t3_if_data", if_data, 32'h44332211);
        chk("t3_no_lsb_done", {31'd0, lsb_done}, 32'd0);
      end
      if (c == 8) chk("t3_then_lsb", mem_a, 32'h103);
      if (c == 10) begin
        chk("t3_lsb_done", {31'd0, lsb_done}, 32'd1);
        chk("t3_lsb_rdata", lsb_rdata, 32'h00000044);
      end
      if (c == 12) begin
        chk("t3_if_again", mem_a, 32'h100);
        if_req = 1'b0; lsb_req = 1'b0;
      end
      if (c == 17) chk("t3_if_done2", {31'd0, if_done}, 32'd1);
      if (c == 18) chk("t3_if_done_end", {31'd0, if_done}, 32'd0);
    end

    // SB to 0x30000 with three cycles of I/O back-pressure
    drive_lsb(1'b1, 1'b1, 2'd0, 32'h30000, 32'h0000005A);
    wr_base = wr_cnt;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) io_buffer_full = 1'b1;
      if (c == 4) io_buffer_full = 1'b0;
      #1;
      if (c <= 3) begin
        chk("t4_stall_wr", {31'd0, mem_wr}, 32'd0);
        chk("t4_stall_a", mem_a, 32'h30000);
      end
      if (c == 4) begin
        chk("t4_wr", {31'd0, mem_wr}, 32'd1);
        chk("t4_dout", {24'd0, mem_dout}, 32'h5A);
      end
      chk("t4_lsb_done", {31'd0, lsb_done}, {31'd0, c == 5});
      if (c == 5) begin
        chk("t4_one_write", 32'(wr_cnt - wr_base), 32'd1);
        lsb_req = 1'b0;
      end
    end

    // Flush during a fetch, then a flushed-through SH
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) begin clear = 1'b1; if_req = 1'b0; end
      if (c == 3) begin
        clear = 1'b0;
        drive_lsb(1'b1, 1'b1, 2'd1, 32'h210, 32'h0000BEEF);
      end
      if (c == 4) clear = 1'b1;
      if (c == 6) clear = 1'b0;
      #1;
      if (c == 1) chk("t5_fetch_a", mem_a, 32'h100);
      if (c <= 3) chk("t5_no_wr", {31'd0, mem_wr}, 32'd0);
      if (c == 3) chk("t5_a_held", mem_a, 32'h101);
      if (c == 4) begin
        chk("t5_sh_a0", mem_a, 32'h210);
        chk("t5_sh_d0", {24'd0, mem_dout}, 32'hEF);
        chk("t5_sh_w0", {31'd0, mem_wr}, 32'd1);
      end
      if (c == 5) begin
        chk("t5_sh_a1", mem_a, 32'h211);
        chk("t5_sh_d1", {24'd0, mem_dout}, 32'hBE);
        chk("t5_sh_w1", {31'd0, mem_wr}, 32'd1);
      end
      if (c == 6) begin
        chk("t5_lsb_done", {31'd0, lsb_done}, 32'd1);
        lsb_req = 1'b0;
      end
      chk("t5_no_if_done", {31'd0, if_done}, 32'd0);
      if (c == 8) chk("t5_if_data_held", if_data, 32'h44332211);
    end

    // Flush in IDLE blocks the fetch that would otherwise win the tie
    clear = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    drive_lsb(1'b1, 1'b0, 2'd1, 32'h101, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin clear = 1'b0; if_req = 1'b0; end
      #1;
      if (c == 1) chk("t6_lsb_granted", mem_a, 32'h101);
      if (c == 4) begin
        chk("t6_lsb_done", {31'd0, lsb_done}, 32'd1);
        chk("t6_lsb_rdata", lsb_rdata, 32'h00003322);
        lsb_req = 1'b0;
      end
      chk("t6_no_if_done", {31'd0, if_done}, 32'd0);
    end

    // Reset during the second beat of a SW
    drive_lsb(1'b1, 1'b1, 2'd2, 32'h220, 32'h11223344);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) rst_in = 1'b1;
      #1;
      if (c == 1) begin
        chk("t7_w0", {31'd0, mem_wr}, 32'd1);
        chk("t7_d0", {24'd0, mem_dout}, 32'h44);
      end
      if (c == 2) begin
        chk("t7_a1", mem_a, 32'h221);
        lsb_req = 1'b0;
        rst_in = 1'b0;
        #1;
        chk_all_zero("t7_rst");
      end
      if (c >= 3) begin
        chk("t7_no_done", {31'd0, lsb_done}, 32'd0);
        chk("t7_no_wr", {31'd0, mem_wr}, 32'd0);
      end
    end

    // rdy_in low freezes a pending SB and masks the strobe
    drive_lsb(1'b1, 1'b1, 2'd0, 32'h240, 32'h00000077);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) rdy_in = 1'b0;
      if (c == 3) rdy_in = 1'b1;
      #1;
      if (c <= 2) begin
        chk("t8_frozen_wr", {31'd0, mem_wr}, 32'd0);
        chk("t8_frozen_a", mem_a, 32'h240);
      end
      if (c == 3) begin
        chk("t8_wr", {31'd0, mem_wr}, 32'd1);
        chk("t8_dout", {24'd0, mem_dout}, 32'h77);
      end
      chk("t8_lsb_done", {31'd0, lsb_done}, {31'd0, c == 4});
      if (c == 4) lsb_req = 1'b0;
    end

    // Fetch across the top of the address space
    if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) chk("t9_wrap_a", mem_a, 32'hFFFF_FFFE + 32'(c - 1));
      chk("t9_if_done", {31'd0, if_done}, {31'd0, c == 6});
      if (c == 6) begin
        chk("t9_if_data", if_data, 32'h005AC2C1);
        if_req = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
